// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - multi-cycle MIPS multiply/divide unit with HI/LO registers
module mdu_iter #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_CYC = (MUL_CYCLES > WIDTH + 1) ? MUL_CYCLES : WIDTH + 1;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] MUL_LAST = CW'(MUL_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t             state, next_state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem, dvsr;
  logic               neg_q, neg_r, b_zero;

  logic               accept, acc_mul, acc_div, wr_hi, wr_lo, last, commit;
  logic               is_signed, ge;
  logic [2*WIDTH-1:0] a_ext, b_ext, mul_prod;
  logic [WIDTH-1:0]   mag_a, mag_b, diff, quo_fix, rem_fix;
  logic [WIDTH:0]     shifted;

  assign busy = (state != IDLE);

  // Operand preparation and one restoring-division step
  always_comb begin
    is_signed = !op[0];
    a_ext     = is_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    b_ext     = is_signed ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
    mul_prod  = a_ext * b_ext;
    mag_a     = (is_signed && a[WIDTH-1]) ? -a : a;
    mag_b     = (is_signed && b[WIDTH-1]) ? -b : b;
    shifted   = {rem, quo[WIDTH-1]};
    ge        = (shifted >= {1'b0, dvsr});
    diff      = shifted[WIDTH-1:0] - dvsr;
    quo_fix   = neg_q ? -quo : quo;
    rem_fix   = neg_r ? -rem : rem;
  end

  always_comb begin
    next_state = state;
    accept     = start && (state == IDLE) && !flush;
    acc_mul    = accept && (op == 3'd0 || op == 3'd1);
    acc_div    = accept && (op == 3'd2 || op == 3'd3);
    wr_hi      = accept && (op == 3'd4);
    wr_lo      = accept && (op == 3'd5);
    last       = ((state == MUL) && (cnt == MUL_LAST)) ||
                 ((state == DIV) && (cnt == DIV_LAST));
    commit     = last && !flush;
    case (state)
      IDLE: begin
        if (acc_mul)      next_state = MUL;
        else if (acc_div) next_state = DIV;
      end
      MUL, DIV: begin
        if (flush || last) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      prod     <= '0;
      quo      <= '0;
      rem      <= '0;
      dvsr     <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      b_zero   <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= commit;
      cnt  <= (state != IDLE && next_state != IDLE) ? cnt + CW'(1) : '0;
      if (acc_mul) prod <= mul_prod;
      if (acc_div) begin
        quo      <= mag_a;
        rem      <= '0;
        dvsr     <= mag_b;
        neg_q    <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
        neg_r    <= is_signed && a[WIDTH-1];
        b_zero   <= (b == '0);
        div_zero <= 1'b0;
      end
      if (state == DIV && cnt < DIV_LAST) begin
        rem <= ge ? diff : shifted[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], ge};
      end
      // A zero divisor still runs the full latency but leaves HI/LO alone
      if (commit && state == MUL) begin
        {hi, lo} <= prod;
      end else if (commit && state == DIV) begin
        if (b_zero) begin
          div_zero <= 1'b1;
        end else begin
          hi <= rem_fix;
          lo <= quo_fix;
        end
      end
      if (wr_hi) hi <= a;
      if (wr_lo) lo <= a;
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// tb/tb_mdu_iter.sv - self-checking bench for mdu_iter (WIDTH=32, MUL_CYCLES=5)
module tb_mdu_iter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int tests = 0;
  int fails = 0;

  logic [31:0] m_hi, m_lo;
  logic        m_dz;

  typedef struct {
    logic [2:0]  o;
    logic [31:0] x, y, eh, el;
    logic        ed;
    int          ec;
  } vec_t;
  vec_t tbl[10];

  mdu_iter #(.WIDTH(32), .MUL_CYCLES(5)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .busy(busy), .done(done), .div_zero(div_zero),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Architectural result computed with plain 64-bit arithmetic
  task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       output int cyc);
    longint sx, sy, q, r;
    logic [63:0] p;
    cyc = 0;
    case (o)
      3'd0: begin
        p = longint'($signed(x)) * longint'($signed(y));
        {m_hi, m_lo} = p;
        cyc = 5;
      end
      3'd1: begin
        p = {32'd0, x} * {32'd0, y};
        {m_hi, m_lo} = p;
        cyc = 5;
      end
      3'd2, 3'd3: begin
        cyc = 33;
        if (y == 32'd0) begin
          m_dz = 1'b1;
        end else begin
          m_dz = 1'b0;
          if (o == 3'd2) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
          end else begin
            sx = longint'({32'd0, x});
            sy = longint'({32'd0, y});
          end
          q = sx / sy;
          r = sx % sy;
          m_lo = q[31:0];
          m_hi = r[31:0];
        end
      end
      3'd4: m_hi = x;
      3'd5: m_lo = x;
      default: ;
    endcase
  endtask

  // Called at a negedge; leaves the bench at the negedge where busy has fallen
  task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el,
                       input logic ed, input int ec);
    int n;
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk({tag, " busy_cycles"}, n, ec);
    chk({tag, " done"}, done, (ec > 0));
    chk({tag, " hi"}, hi, eh);
    chk({tag, " lo"}, lo, el);
    chk({tag, " div_zero"}, div_zero, ed);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int ec, n;
    logic [2:0] o;
    logic [31:0] x, y;
    logic saw;

    tbl[0] = '{3'd0, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 5};
    tbl[1] = '{3'd1, 32'hFFFF_FFFF, 32'd2,        32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 5};
    tbl[2] = '{3'd0, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 5};
    tbl[3] = '{3'd2, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33};
    tbl[4] = '{3'd3, 32'hFFFF_FFF9, 32'd2,        32'h0000_0001, 32'h7FFF_FFFC, 1'b0, 33};
    tbl[5] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 33};
    tbl[6] = '{3'd3, 32'd7,         32'd0,        32'h0000_0000, 32'h8000_0000, 1'b1, 33};
    tbl[7] = '{3'd4, 32'h0000_1234, 32'd0,        32'h0000_1234, 32'h8000_0000, 1'b1, 0};
    tbl[8] = '{3'd2, 32'd100,       32'd7,        32'd2,         32'd14,        1'b0, 33};
    tbl[9] = '{3'd6, 32'h0000_FFFF, 32'd3,        32'd2,         32'd14,        1'b0, 0};

    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset div_zero", div_zero, 0);
    chk("reset hi", hi, 0);
    chk("reset lo", lo, 0);
    reset = 1'b1;
    @(negedge clk);

    // Directed vectors, issued back-to-back in the done cycle
    for (int i = 0; i < 10; i++)
      do_op($sformatf("vec%0d", i), tbl[i].o, tbl[i].x, tbl[i].y,
            tbl[i].eh, tbl[i].el, tbl[i].ed, tbl[i].ec);

    m_hi = 32'd2; m_lo = 32'd14; m_dz = 1'b0;
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      x = pick();
      y = pick();
      model(o, x, y, ec);
      do_op($sformatf("rnd%0d op%0d", i, o), o, x, y, m_hi, m_lo, m_dz, ec);
    end

    // Flush mid-divide with an ignored start while busy
    model(3'd4, 32'h0000_1234, 32'd0, ec);
    do_op("mthi", 3'd4, 32'h0000_1234, 32'd0, m_hi, m_lo, m_dz, 0);
    start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    m_dz = 1'b0;
    for (int k = 1; k < 10; k++) begin
      if (k == 4) begin start = 1'b1; op = 3'd5; a = 32'd999; end
      @(negedge clk);
      start = 1'b0;
      chk($sformatf("flushdiv busy k%0d", k), busy, 1);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flushdiv busy after", busy, 0);
    chk("flushdiv done", done, 0);
    chk("flushdiv hi", hi, 32'h0000_1234);
    chk("flushdiv lo", lo, m_lo);
    saw = 1'b0;
    for (int k = 0; k < 35; k++) begin
      @(negedge clk);
      if (done || busy) saw = 1'b1;
    end
    chk("flushdiv no late done", saw, 0);

    // Flush together with start blocks MTLO
    start = 1'b1; op = 3'd5; a = 32'h0000_ABCD; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("flush+start lo", lo, m_lo);
    chk("flush+start busy", busy, 0);

    // Flush on the commit edge of a multiply
    start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("commitflush busy last", busy, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("commitflush done", done, 0);
    chk("commitflush busy", busy, 0);
    chk("commitflush hi", hi, m_hi);
    chk("commitflush lo", lo, m_lo);

    // Asynchronous reset in the middle of a divide
    start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    repeat (5) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("areset busy", busy, 0);
    chk("areset done", done, 0);
    chk("areset hi", hi, 0);
    chk("areset lo", lo, 0);
    chk("areset div_zero", div_zero, 0);
    @(negedge clk);
    reset = 1'b1;
    m_hi = '0; m_lo = '0; m_dz = 1'b0;
    do_op("mtlo5", 3'd5, 32'd5, 32'd0, 32'd0, 32'd5, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers.
- Serves the pipelined MIPS datapath in the EX stage.
- Runs MULT/MULTU/DIV/DIVU over multiple cycles and raises busy so the hazard unit can stall later HI/LO readers and further MDU ops.
- Also handles MTHI/MTLO and supports flush-abort for exception/branch squash.

Parameters:
- WIDTH, 32, operand and HI/LO width; must be ≥4 and even.
- MUL_CYCLES, 5, busy cycles for a multiply; must be ≥1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  launch op; sampled on the rising edge.
- op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op.
- a  input  WIDTH  rs operand (dividend / multiplicand / MTHI/MTLO data).
- b  input  WIDTH  rt operand (divisor / multiplier).
- flush  input  1  abort the in-flight op.
- busy  output  1  an op is in progress.
- done  output  1  one-cycle pulse: result committed.
- div_zero  output  1  last divide had b==0; held until the next divide start.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (reset==0, asynchronous): hi=0, lo=0, busy=0, done=0, div_zero=0, state IDLE, counter 0. A reset mid-operation discards the op.
- States:
  - IDLE → MUL on start&&op∈{0,1}&&!busy&&!flush.
  - IDLE → DIV on start&&op∈{2,3}&&!busy&&!flush.
  - MUL → IDLE after MUL_CYCLES cycles.
  - DIV → IDLE after WIDTH+1 cycles.
  - Any state → IDLE on flush.
- Start acceptance: start is accepted only in IDLE. start while busy is ignored entirely; no queueing.
- MTHI/MTLO (start, op 4/5, in IDLE, !flush): write a into hi/lo on that edge. busy stays 0 and done stays 0.
- Multiply:
  - On the accepting edge, latch the 2*WIDTH product: signed for MULT, unsigned for MULTU.
  - busy=1 for exactly MUL_CYCLES cycles.
  - On the edge ending busy, {hi,lo} ← product.
  - done=1 for the following cycle, with busy=0 and the new hi/lo visible.
- Divide: restoring algorithm, one quotient bit per cycle.
  - Accept edge: latch |a|, |b| (raw values for DIVU) and the sign flags.
  - WIDTH iteration cycles, then 1 fix-up cycle, so busy=1 for WIDTH+1 cycles.
  - Fix-up: quotient negated iff DIV and the signs differ; remainder takes the sign of a (DIV only).
  - Commit: lo←quotient, hi←remainder, then done pulse as for multiply.
  - Magnitudes are taken as WIDTH-bit unsigned. DIV of MIN/-1 gives lo=MIN, hi=0 (wraps, no trap).
- Divide by zero (b==0 at start):
  - busy and latency are unchanged.
  - hi/lo are NOT written.
  - done pulses and div_zero=1.
  - div_zero clears on the next accepted DIV/DIVU.
- Flush:
  - Synchronous. State returns to IDLE on the next edge with busy=0, done=0, hi/lo unchanged.
  - flush on the commit edge wins: no commit.
  - flush together with start blocks acceptance, including MTHI/MTLO.
- Back-to-back: a new start is accepted in the same cycle done=1, since busy=0 then.
- hi/lo change only on commit, MTHI/MTLO or reset.

Test Plan (WIDTH=32, MUL_CYCLES=5):
- MULT a=FFFFFFFD (−3), b=5 → busy high 5 cycles; then hi=FFFFFFFF, lo=FFFFFFF1, done one cycle.
- MULTU a=FFFFFFFF, b=2 → hi=00000001, lo=FFFFFFFE. MULT with the same operands → hi=FFFFFFFF, lo=FFFFFFFE.
- DIV a=FFFFFFF9 (−7), b=2 → busy 33 cycles; lo=FFFFFFFD, hi=FFFFFFFF. DIVU with the same operands → lo=7FFFFFFC, hi=1.
- DIV a=80000000, b=FFFFFFFF → lo=80000000, hi=0. Then DIVU a=7, b=0 → hi/lo unchanged, div_zero=1, done pulses after 33 cycles.
- MTHI 1234, then DIV 100/7 with flush at cycle 10 → busy drops next edge, hi=1234, no done. A start during busy is ignored (verify hi/lo, busy count).
- Mid-DIV drive reset=0 asynchronously → busy, done, hi, lo go 0 immediately without a clock. After release, MTLO 5 → lo=5 next edge.
